bcd_mod_checker: RTL

BCD_MOD_CHECKER -- requirements
Module: bcd_mod_checker

---
 rtl/bcd_mod_checker.sv | 95 +++++++++
 1 files changed

// File: rtl/bcd_mod_checker.sv
// Streaming BCD modulus checker: folds MSD-first BCD digits into a running
// remainder and holds one result per frame until downstream consumes it.
module bcd_mod_checker #(
  parameter int DIVISOR    = 3,
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       divisible,
  output logic [3:0] remainder,
  output logic [4:0] digit_count,
  output logic       bcd_error
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] DIV8 = 8'(DIVISOR);
  localparam logic [4:0] MAX5 = 5'(MAX_DIGITS);

  state_t     state, state_next;
  logic [3:0] rem, rem_next;
  logic [4:0] cnt, cnt_next;
  logic       err, err_next;
  logic       accept;
  logic       frame_end;

  // With r < DIVISOR the sum 10*r+d stays below 16*DIVISOR, so four
  // restoring subtractions of DIVISOR*8/4/2/1 always reduce it fully.
  function automatic logic [3:0] mod_step(input logic [3:0] r, input logic [3:0] d);
    logic [7:0] acc;
    acc = ({4'd0, r} << 3) + ({4'd0, r} << 1) + {4'd0, d};
    for (int i = 3; i >= 0; i--) begin
      if (acc >= (DIV8 << i)) acc = acc - (DIV8 << i);
    end
    return acc[3:0];
  endfunction

  assign accept    = din_valid && (state == ACCUM);
  assign frame_end = accept && (din_last || ((cnt + 5'd1) == MAX5));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      rem   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      cnt   <= cnt_next;
      err   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    rem_next   = rem;
    cnt_next   = cnt;
    err_next   = err;
    case (state)
      ACCUM: begin
        if (accept) begin
          rem_next = mod_step(rem, din);
          cnt_next = cnt + 5'd1;
          err_next = err || (din > 4'd9);
          if (frame_end) state_next = HOLD;
        end
      end
      HOLD: begin
        // Digits offered during the handshake cycle are left for ACCUM.
        if (res_ready) begin
          state_next = ACCUM;
          rem_next   = '0;
          cnt_next   = '0;
          err_next   = 1'b0;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  assign din_ready   = (state == ACCUM);
  assign res_valid   = (state == HOLD);
  assign remainder   = res_valid ? rem : 4'd0;
  assign digit_count = res_valid ? cnt : 5'd0;
  assign bcd_error   = res_valid && err;
  assign divisible   = res_valid && (rem == 4'd0) && !err;

endmodule
